// File: rtl/pattern_tx.sv
// pattern_tx: serial transmitter for the pattern-detector bit stream.
// Words enter through a small FIFO (valid/ready) and leave LSB-first on
// bit_stream, with 'start' flagging bit 0 of every word and an optional
// idle gap of GAP cycles between words.
// Optional feature macro: PATTERN_TX_ERR_INJ_EN adds err_inj/err_done, which
// invert bit 0 of the next popped word once per err_inj request.
module pattern_tx #(
    parameter int   WIDTH    = 4,
    parameter int   DEPTH    = 2,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_stream,
    output logic             start,
    output logic             busy,
    output logic             word_done,
    output logic [15:0]      word_cnt
`ifdef PATTERN_TX_ERR_INJ_EN
    ,
    input  logic             err_inj,
    output logic             err_done
`endif
);

    localparam int IW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [IW-1:0] PRE_LAST = IW'(WIDTH - 2);
    localparam logic [7:0]    GAP_LEN  = 8'(GAP);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [7:0]       gap_cnt, gap_nxt;
    logic             bit_nxt;
    logic             start_nxt;
    logic             done_nxt;
    logic             inj;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = in_valid && !full;
    assign in_ready = !full;
    assign head     = mem[rd_ptr];
    assign busy     = (state != S_IDLE) || !empty;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef PATTERN_TX_ERR_INJ_EN
    logic err_armed;
    logic err_word;

    assign inj = err_armed;

    // One-shot corruption request: armed by err_inj, consumed by the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_armed <= 1'b0;
            err_word  <= 1'b0;
            err_done  <= 1'b0;
        end else begin
            if (err_inj) begin
                err_armed <= 1'b1;
            end else if (pop) begin
                err_armed <= 1'b0;
            end
            if (pop) begin
                err_word <= err_armed;
            end
            err_done <= done_nxt && err_word;
        end
    end
`else
    assign inj = 1'b0;
`endif

    // Next-state logic: shift out the current word, then gap, then reload.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        bit_nxt   = IDLE_BIT;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                pop = !empty;
            end
            S_SHIFT: begin
                if (idx != LAST_IDX) begin
                    bit_nxt   = shreg[0];
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = idx + 1'b1;
                    done_nxt  = (idx == PRE_LAST);
                end else if (GAP > 0) begin
                    state_nxt = S_GAP;
                    gap_nxt   = 8'd1;
                end else begin
                    pop       = !empty;
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt != GAP_LEN) begin
                    gap_nxt = gap_cnt + 1'b1;
                end else begin
                    pop       = !empty;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (pop) begin
            bit_nxt   = head[0] ^ inj;
            shreg_nxt = head >> 1;
            start_nxt = 1'b1;
            idx_nxt   = '0;
            state_nxt = S_SHIFT;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            bit_stream <= IDLE_BIT;
            start      <= 1'b0;
            word_done  <= 1'b0;
            word_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            idx        <= idx_nxt;
            gap_cnt    <= gap_nxt;
            bit_stream <= bit_nxt;
            start      <= start_nxt;
            word_done  <= done_nxt;
            if (done_nxt) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: one instance with GAP=0, one with GAP=2.
// Outputs are sampled on the falling clock edge; inputs also change there.
module tb_pattern_tx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_valid_g;
    logic        err_inj;

    logic        in_ready, bit_stream, start, busy, word_done;
    logic [15:0] word_cnt;
    logic        g_in_ready, g_bit_stream, g_start, g_busy, g_word_done;
    logic [15:0] g_word_cnt;
    logic        err_done;
    logic        g_err_done;

    logic [31:0] cap_bits, cap_start, cap_done, cap_busy, cap_ready, cap_err;
    int          assertCount;
    int          failCount;

    pattern_tx #(.WIDTH(4), .DEPTH(2), .GAP(0), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bit_stream(bit_stream), .start(start),
        .busy(busy), .word_done(word_done), .word_cnt(word_cnt)
`ifdef PATTERN_TX_ERR_INJ_EN
        , .err_inj(err_inj), .err_done(err_done)
`endif
    );

    pattern_tx #(.WIDTH(4), .DEPTH(2), .GAP(2), .IDLE_BIT(1'b0)) dut_gap (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_g),
        .in_ready(g_in_ready), .bit_stream(g_bit_stream), .start(g_start),
        .busy(g_busy), .word_done(g_word_done), .word_cnt(g_word_cnt)
`ifdef PATTERN_TX_ERR_INJ_EN
        , .err_inj(1'b0), .err_done(g_err_done)
`endif
    );

`ifndef PATTERN_TX_ERR_INJ_EN
    assign err_done   = 1'b0;
    assign g_err_done = 1'b0;
`endif

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one word (call at a falling edge); returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [3:0] d, input bit use_gap);
        bit accepted;
        accepted = 1'b0;
        in_data  = d;
        if (use_gap) in_valid_g = 1'b1;
        else         in_valid   = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (use_gap ? g_in_ready : in_ready) accepted = 1'b1;
            @(negedge clk);
        end
        in_valid   = 1'b0;
        in_valid_g = 1'b0;
        checkOutput("push_accepted", 32'(accepted), 32'd1);
    endtask

    // Record n consecutive falling-edge samples; sample i goes to bit i.
    task automatic capture(input int n, input bit use_gap);
        cap_bits = '0; cap_start = '0; cap_done = '0;
        cap_busy = '0; cap_ready = '0; cap_err = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (use_gap) begin
                cap_bits[i]  = g_bit_stream;
                cap_start[i] = g_start;
                cap_done[i]  = g_word_done;
                cap_busy[i]  = g_busy;
                cap_ready[i] = g_in_ready;
                cap_err[i]   = g_err_done;
            end else begin
                cap_bits[i]  = bit_stream;
                cap_start[i] = start;
                cap_done[i]  = word_done;
                cap_busy[i]  = busy;
                cap_ready[i] = in_ready;
                cap_err[i]   = err_done;
            end
        end
    endtask

    // Hard stop if anything stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_valid_g = 1'b0;
        err_inj    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_bit", 32'(bit_stream), 32'd0);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_done", 32'(word_done), 32'd0);
        checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single word 0101");
        fork
            applyStimulus(4'b0101, 1'b0);
            capture(6, 1'b0);
        join
        checkOutput("w1_bits", cap_bits, 32'h0A);
        checkOutput("w1_start", cap_start, 32'h02);
        checkOutput("w1_done", cap_done, 32'h10);
        checkOutput("w1_busy", cap_busy, 32'h1F);
        checkOutput("w1_cnt", 32'(word_cnt), 32'd1);

        $display("[TB] back-to-back A,5");
        fork
            begin
                applyStimulus(4'hA, 1'b0);
                applyStimulus(4'h5, 1'b0);
            end
            capture(10, 1'b0);
        join
        checkOutput("b2b_bits", cap_bits, 32'h0B4);
        checkOutput("b2b_start", cap_start, 32'h022);
        checkOutput("b2b_done", cap_done, 32'h110);
        checkOutput("b2b_busy", cap_busy, 32'h1FF);
        checkOutput("b2b_cnt", 32'(word_cnt), 32'd3);

        $display("[TB] fifo fill with four words");
        fork
            begin
                applyStimulus(4'h3, 1'b0);
                applyStimulus(4'hC, 1'b0);
                applyStimulus(4'h9, 1'b0);
                applyStimulus(4'h6, 1'b0);
            end
            capture(18, 1'b0);
        join
        checkOutput("fill_bits", cap_bits, 32'h0D386);
        checkOutput("fill_start", cap_start, 32'h02222);
        checkOutput("fill_done", cap_done, 32'h11110);
        checkOutput("fill_ready", cap_ready, 32'h3FE23);
        checkOutput("fill_busy", cap_busy, 32'h1FFFF);
        checkOutput("fill_cnt", 32'(word_cnt), 32'd7);

        $display("[TB] gap of two cycles");
        fork
            begin
                applyStimulus(4'h7, 1'b1);
                applyStimulus(4'h1, 1'b1);
            end
            capture(14, 1'b1);
        join
        checkOutput("gap_bits", cap_bits, 32'h008E);
        checkOutput("gap_start", cap_start, 32'h0082);
        checkOutput("gap_done", cap_done, 32'h0410);
        checkOutput("gap_busy", cap_busy, 32'h1FFF);
        checkOutput("gap_cnt", 32'(g_word_cnt), 32'd2);

        $display("[TB] reset mid-word");
        applyStimulus(4'hF, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_bit", 32'(bit_stream), 32'd0);
        checkOutput("mid_rst_cnt", 32'(word_cnt), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        capture(6, 1'b0);
        checkOutput("post_rst_bits", cap_bits, 32'h0);
        checkOutput("post_rst_start", cap_start, 32'h0);
        checkOutput("post_rst_busy", cap_busy, 32'h0);
        checkOutput("post_rst_cnt", 32'(word_cnt), 32'd0);

        $display("[TB] word counter wrap");
        force dut.word_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt;
        #1;
        checkOutput("wrap_preload", 32'(word_cnt), 32'h0000FFFF);
        @(negedge clk);
        fork
            applyStimulus(4'h9, 1'b0);
            capture(6, 1'b0);
        join
        checkOutput("wrap_bits", cap_bits, 32'h12);
        checkOutput("wrap_done", cap_done, 32'h10);
        checkOutput("wrap_cnt", 32'(word_cnt), 32'd0);

`ifdef PATTERN_TX_ERR_INJ_EN
        $display("[TB] error injection");
        err_inj = 1'b1;
        @(negedge clk);
        err_inj = 1'b0;
        fork
            applyStimulus(4'b0101, 1'b0);
            capture(6, 1'b0);
        join
        checkOutput("err_bits", cap_bits, 32'h08);
        checkOutput("err_done", cap_err, 32'h10);
        checkOutput("err_word_done", cap_done, 32'h10);
        checkOutput("err_cnt", 32'(word_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Serial transmitter for the single-bit pattern stream: accepts parallel words over a valid/ready interface and serializes them LSB-first onto bit_stream.
- Asserts a start qualifier on the first bit of each word, so the downstream pattern detector aligns its match to word boundaries.
- Sits between test/traffic sources and the detector; includes a small input FIFO and a configurable inter-word idle gap.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- DEPTH, 2, input FIFO entries; power of two, 2..16.
- GAP, 0, idle cycles inserted after each word; legal range 0..255.
- IDLE_BIT, 1'b0, value driven on bit_stream when not transmitting.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  word to transmit; bit 0 is sent first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid && in_ready at a clock edge.
- bit_stream  out  1  registered serial data.
- start  out  1  registered; high only during the cycle bit 0 of a word is on bit_stream.
- busy  out  1  high while in SHIFT or GAP, or while the FIFO is non-empty.
- word_done  out  1  one-cycle pulse, coincident with the last bit of each word.
- word_cnt  out  16  words fully transmitted; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async assert, sync release) drives these values:
  - bit_stream=IDLE_BIT, start=0, word_done=0, word_cnt=0.
  - FIFO empty, so in_ready=1 and busy=0.
  - State is IDLE.
  - Any word in flight or queued is discarded; no partial word resumes.
- FIFO:
  - in_ready = !full; no push when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full.
  - Order is preserved.
- State machine (IDLE, SHIFT, GAP):
  - IDLE, FIFO empty: stay in IDLE and drive IDLE_BIT.
  - IDLE, FIFO non-empty: pop into the shift register, drive bit 0 with start=1, go to SHIFT with bit index 1.
  - SHIFT: drive bit[idx], start=0, idx++.
  - SHIFT, at idx==WIDTH-1: drive the last bit, pulse word_done, increment word_cnt.
  - SHIFT exit after the last bit:
    - GAP>0: go to GAP.
    - GAP==0 and FIFO non-empty: pop the next word and drive its bit 0 with start=1 in the very next cycle (back-to-back, no bubble).
    - Otherwise: go to IDLE.
  - GAP: drive IDLE_BIT for exactly GAP cycles, then apply the same pop-or-IDLE decision as the SHIFT exit.
- Latency: for a word accepted at edge k into an empty FIFO with the block in IDLE, bit 0 and start are visible after edge k+1.
- Throughput: one word per WIDTH+GAP cycles.
- in_data changes while a word is shifting do not affect that word (it is captured at pop).
- busy falls in the same cycle the block returns to IDLE with the FIFO empty.

Optional Feature:
- Macro: PATTERN_TX_ERR_INJ_EN.
- When defined:
  - Adds input err_inj (1 bit) and output err_done (1 bit).
  - A high sample of err_inj arms a one-shot flag, which is cleared only when it is consumed (by a popped word) or by reset.
  - The next word popped has its bit 0 inverted on bit_stream.
  - err_done pulses with that word's word_done.
  - word_cnt still counts the corrupted word.
- When undefined: no extra ports; data is sent unmodified.

Test Plan:
- WIDTH=4, GAP=0: push 4'b0101 into idle block -> bit_stream 1,0,1,0 over 4 cycles starting 2 edges after acceptance; start high on first cycle only; word_done on 4th; word_cnt=1.
- Push 4'hA then 4'h5 back-to-back, GAP=0 -> 0,1,0,1,1,0,1,0 with no bubble; start on cycles 1 and 5; word_cnt=2.
- DEPTH=2: hold in_valid with 4 words while the first shifts -> in_ready drops after FIFO fills; all 4 words emitted in order; no word lost or duplicated.
- GAP=2: two words -> exactly 2 cycles of IDLE_BIT between last bit of word 1 and start of word 2; busy stays high throughout.
- Assert rst_n low mid-word (after bit 1) -> outputs go to reset values immediately (async); after release the block stays in IDLE with busy=0 and no remaining bits.
- word_cnt preloaded via 65535 words (or forced) -> next word_done wraps word_cnt to 0. With PATTERN_TX_ERR_INJ_EN defined, pulse err_inj then push 4'b0101 -> bit_stream 0,0,1,0 and err_done coincident with word_done.
